lockstep_checker: RTL and testbench
===================================

// Module: lockstep_checker
// PURPOSE
//   Compares the retired outputs of two lockstepped cores each cycle and raises error_o toward the recovery controller.
//   Sits directly upstream of the recovery controller: error_o feeds its error input; its enable/resume outputs feed back here.
//   Masks comparison while recovery runs. Counts recovered faults; flags a permanent fault at threshold.
// PARAMETERS
//   DATA_WIDTH   32  width of each core's compared output word (addr/wdata/we packed by integrator)
//   GUARD_CYCLES 4   cycles after resume_i during which comparison stays masked (pipeline refill)
//   FAULT_THRESH 8   recovered-fault count at which perm_fault_o sets; min 1
// PORTS
//   clk_i          in   1           clock, rising edge
//   rst_ni         in   1           asynchronous reset, active low
//   a_valid_i      in   1           core A output word valid
//   a_data_i       in   DATA_WIDTH  core A output word
//   b_valid_i      in   1           core B output word valid
//   b_data_i       in   DATA_WIDTH  core B output word
//   enable_i       in   1           controller enable; low = recovery in progress
//   resume_i       in   1           controller resume pulse; recovery finished
//   error_o        out  1           mismatch detected, level, held until acknowledged
//   perm_fault_o   out  1           sticky: fault count reached FAULT_THRESH
//   fault_cnt_o    out  8           recovered faults, saturates at 255
// BEHAVIOUR
//   Reset: error_o=0, perm_fault_o=0, fault_cnt_o=0, state=CHECK, guard counter=0.
//   Inputs registered once; mismatch evaluated on registered copies -> error_o rises 2 cycles after the mismatching input edge.
//   Mismatch = (a_valid!=b_valid) | (a_valid & b_valid & a_data!=b_data). Data ignored when both valid low.
//   FSM (states in ft_pkg::chk_state_e):
//     CHECK:   compare only when enable_i=1; mismatch -> FLAGGED, error_o<=1.
//     FLAGGED: error_o held 1; enable_i==0 (ack) -> RECOVER, error_o<=0, fault_cnt_o+=1 (saturating).
//     RECOVER: no comparison; resume_i -> GUARD, guard counter<=GUARD_CYCLES-1.
//     GUARD:   no comparison; counter decrements; at 0 -> CHECK. GUARD_CYCLES=0 -> RECOVER goes straight to CHECK.
//   error_o must be 0 before controller returns to its idle state, so one fault never triggers two recoveries.
//   perm_fault_o sets the cycle fault_cnt_o reaches FAULT_THRESH; cleared only by reset. Comparison continues after it.
//   resume_i in CHECK/FLAGGED ignored. enable_i low in CHECK (no mismatch): comparison suppressed, no state change.
//   Mismatch and enable_i fall in same cycle while in CHECK: mismatch ignored (enable_i gates).
//   Reset mid-recovery: all state returns to reset values immediately; counter lost.
// CONFIGURATION
//   LOCKSTEP_CHECKER_DIVERGE_LOG_EN defined: adds outputs diverge_a_o, diverge_b_o [DATA_WIDTH] and syndrome_o [DATA_WIDTH]=a^b,
//     captured on the CHECK->FLAGGED transition, held until next capture, reset to 0.
//   Undefined: ports and registers absent; all other behaviour identical.
// STRUCTURE
//   ft_pkg: chk_state_e enum (CHECK, FLAGGED, RECOVER, GUARD), FAULT_CNT_W=8 constant.
//   Sub-module lockstep_fault_counter: saturating counter + threshold compare driving fault_cnt_o/perm_fault_o.
//   FSM, input registers, guard counter in top module.
// TESTING
//   T1 equal streams, a=b=32'hDEAD_BEEF valid 100 cycles -> error_o stays 0, fault_cnt_o=0.
//   T2 b_data=32'hDEAD_BEEE one cycle -> error_o=1 two cycles later, held until enable_i=0, then 0; fault_cnt_o=1.
//   T3 a_valid=1,b_valid=0 one cycle -> error_o asserts; mismatch injected during RECOVER and within 4 guard cycles -> no new error.
//   T4 8 inject/ack/resume loops -> perm_fault_o=1 after 8th ack; 300 loops -> fault_cnt_o=255.
//   T5 rst_ni low while in RECOVER -> error_o, fault_cnt_o, perm_fault_o = 0 asynchronously; CHECK after release.
//   T6 DIVERGE_LOG_EN: a=32'h0000_00F0,b=32'h0000_00FF -> syndrome_o=32'h0000_000F, diverge regs hold inputs.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types for the lockstep fault-tolerance slice.
// Holds the checker state enum and fault counter width.
package ft_pkg;

  typedef enum logic [1:0] {
    CHECK,
    FLAGGED,
    RECOVER,
    GUARD
  } chk_state_e;

  localparam int FAULT_CNT_W = 8;

endpackage

// File: rtl/lockstep_fault_counter.sv
// Saturating recovered-fault counter with a sticky
// permanent-fault flag raised at the threshold.
module lockstep_fault_counter
  import ft_pkg::*;
#(
  parameter int unsigned FAULT_THRESH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inc_i,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o,
  output logic                   perm_fault_o
);

  logic [FAULT_CNT_W-1:0] cnt_d, cnt_q;
  logic                   perm_d, perm_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + FAULT_CNT_W'(1);
    end
    perm_d = perm_q | (32'(cnt_d) >= FAULT_THRESH);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      perm_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      perm_q <= perm_d;
    end
  end

  assign fault_cnt_o  = cnt_q;
  assign perm_fault_o = perm_q;

endmodule

// File: rtl/lockstep_checker.sv
// Dual-core lockstep output comparator feeding the recovery controller.
// LOCKSTEP_CHECKER_DIVERGE_LOG_EN adds diverging-word capture ports.
module lockstep_checker
  import ft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned FAULT_THRESH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   a_valid_i,
  input  logic [DATA_WIDTH-1:0]  a_data_i,
  input  logic                   b_valid_i,
  input  logic [DATA_WIDTH-1:0]  b_data_i,
  input  logic                   enable_i,
  input  logic                   resume_i,
  output logic                   error_o,
  output logic                   perm_fault_o,
  output logic [FAULT_CNT_W-1:0] fault_cnt_o
`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
  ,
  output logic [DATA_WIDTH-1:0]  diverge_a_o,
  output logic [DATA_WIDTH-1:0]  diverge_b_o,
  output logic [DATA_WIDTH-1:0]  syndrome_o
`endif
);

  localparam int unsigned GW =
    (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  logic                  a_valid_q, b_valid_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  chk_state_e            state_d, state_q;
  logic                  error_d, error_q;
  logic [GW-1:0]         guard_d, guard_q;
  logic                  mismatch;
  logic                  inc;
  logic                  capture;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      a_valid_q <= a_valid_i;
      b_valid_q <= b_valid_i;
      a_data_q  <= a_data_i;
      b_data_q  <= b_data_i;
    end
  end

  assign mismatch = (a_valid_q != b_valid_q) |
                    (a_valid_q & b_valid_q & (a_data_q != b_data_q));

  always_comb begin
    state_d = state_q;
    error_d = error_q;
    guard_d = guard_q;
    inc     = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      CHECK: begin
        if (enable_i && mismatch) begin
          state_d = FLAGGED;
          error_d = 1'b1;
          capture = 1'b1;
        end
      end
      FLAGGED: begin
        // Dropping the error on ack keeps one fault to one recovery
        if (!enable_i) begin
          state_d = RECOVER;
          error_d = 1'b0;
          inc     = 1'b1;
        end
      end
      RECOVER: begin
        if (resume_i) begin
          if (GUARD_CYCLES == 0) begin
            state_d = CHECK;
          end else begin
            state_d = GUARD;
            guard_d = GW'(GUARD_CYCLES - 1);
          end
        end
      end
      GUARD: begin
        if (guard_q == '0) begin
          state_d = CHECK;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CHECK;
      error_q <= 1'b0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
      guard_q <= guard_d;
    end
  end

  assign error_o = error_q;

  lockstep_fault_counter #(
    .FAULT_THRESH (FAULT_THRESH)
  ) u_fault_counter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .inc_i        (inc),
    .fault_cnt_o  (fault_cnt_o),
    .perm_fault_o (perm_fault_o)
  );

`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
  logic [DATA_WIDTH-1:0] div_a_d, div_a_q;
  logic [DATA_WIDTH-1:0] div_b_d, div_b_q;
  logic [DATA_WIDTH-1:0] syn_d, syn_q;

  always_comb begin
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    syn_d   = syn_q;
    if (capture) begin
      div_a_d = a_data_q;
      div_b_d = b_data_q;
      syn_d   = a_data_q ^ b_data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_a_q <= '0;
      div_b_q <= '0;
      syn_q   <= '0;
    end else begin
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      syn_q   <= syn_d;
    end
  end

  assign diverge_a_o = div_a_q;
  assign diverge_b_o = div_b_q;
  assign syndrome_o  = syn_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_lockstep_checker.sv
// Directed bench for lockstep_checker with a cycle-level reference model.
module tb_lockstep_checker;

  localparam int THRESH = 8;
  localparam int GUARD  = 4;

  logic        clk;
  logic        rst_n;
  logic        av, bv, en, res;
  logic [31:0] ad, bd;
  logic        error_o, perm_fault_o;
  logic [7:0]  fault_cnt_o;
`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
  logic [31:0] diverge_a_o, diverge_b_o, syndrome_o;
`endif

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  lockstep_checker dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_valid_i    (av),
    .a_data_i     (ad),
    .b_valid_i    (bv),
    .b_data_i     (bd),
    .enable_i     (en),
    .resume_i     (res),
    .error_o      (error_o),
    .perm_fault_o (perm_fault_o),
    .fault_cnt_o  (fault_cnt_o)
`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
    ,
    .diverge_a_o  (diverge_a_o),
    .diverge_b_o  (diverge_b_o),
    .syndrome_o   (syndrome_o)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: previous-cycle words, error flag, waiting-for-resume
  // flag, remaining masked cycles, fault count, sticky permanent flag.
  logic        p_av, p_bv;
  logic [31:0] p_ad, p_bd;
  bit          m_err, m_wait, m_perm;
  int          m_guard, m_cnt;
  logic [31:0] m_da, m_db;

  wire mism = (p_av != p_bv) || (p_av && p_bv && (p_ad != p_bd));

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_av <= 0; p_bv <= 0; p_ad <= 0; p_bd <= 0;
      m_err <= 0; m_wait <= 0; m_perm <= 0;
      m_guard <= 0; m_cnt <= 0; m_da <= 0; m_db <= 0;
    end else begin
      if (m_err) begin
        if (!en) begin
          m_err  <= 0;
          m_wait <= 1;
          m_cnt  <= (m_cnt < 255) ? m_cnt + 1 : 255;
          if (m_cnt + 1 >= THRESH) m_perm <= 1;
        end
      end else if (m_wait) begin
        if (res) begin
          m_wait  <= 0;
          m_guard <= GUARD;
        end
      end else if (m_guard > 0) begin
        m_guard <= m_guard - 1;
      end else if (en && mism) begin
        m_err <= 1;
        m_da  <= p_ad;
        m_db  <= p_bd;
      end
      p_av <= av; p_bv <= bv; p_ad <= ad; p_bd <= bd;
    end
  end

  always @(posedge clk) begin
    if (run) begin
      #1;
      chk("cyc_error", error_o, m_err);
      chk("cyc_perm", perm_fault_o, m_perm);
      chk("cyc_cnt", fault_cnt_o, m_cnt);
`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
      chk("cyc_div_a", diverge_a_o, m_da);
      chk("cyc_div_b", diverge_b_o, m_db);
      chk("cyc_syn", syndrome_o, m_da ^ m_db);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ack_resume();
    en = 0;
    tick();
    res = 1;
    en  = 1;
    tick();
    res = 0;
    repeat (GUARD + 1) tick();
  endtask

  task automatic fault_loop();
    bd = ~ad;
    tick();
    bd = ad;
    tick();
    ack_resume();
  endtask

  initial begin
    av = 0; bv = 0; ad = 0; bd = 0; en = 0; res = 0;
    rst_n = 1;
    #1 rst_n = 0;
    repeat (2) tick();
    chk("rst_error", error_o, 0);
    chk("rst_perm", perm_fault_o, 0);
    chk("rst_cnt", fault_cnt_o, 0);
    rst_n = 1;
    run   = 1;

    // T1 equal streams
    av = 1; bv = 1; ad = 32'hDEAD_BEEF; bd = 32'hDEAD_BEEF; en = 1;
    repeat (100) tick();
    chk("t1_error", error_o, 0);
    chk("t1_cnt", fault_cnt_o, 0);

    // both invalid: data ignored
    av = 0; bv = 0; bd = 32'h1234_5678;
    repeat (3) tick();
    chk("inv_error", error_o, 0);
    av = 1; bv = 1; bd = ad;

    // enable low suppresses comparison
    en = 0; bd = 32'hDEAD_BEEE;
    tick();
    bd = ad;
    repeat (2) tick();
    en = 1;
    repeat (2) tick();
    chk("en_gate_error", error_o, 0);

    // T2 data mismatch, two-cycle latency, held until ack
    bd = 32'hDEAD_BEEE;
    tick();
    bd = ad;
    chk("t2_lat1", error_o, 0);
    tick();
    chk("t2_rise", error_o, 1);
    repeat (3) tick();
    chk("t2_held", error_o, 1);
    en = 0;
    tick();
    chk("t2_ack_error", error_o, 0);
    chk("t2_cnt", fault_cnt_o, 1);
    res = 1; en = 1;
    tick();
    res = 0;
    repeat (GUARD + 1) tick();

    // T3 valid mismatch, then masked during recover and guard
    bv = 0;
    tick();
    bv = 1;
    tick();
    chk("t3_rise", error_o, 1);
    en = 0;
    tick();
    chk("t3_cnt", fault_cnt_o, 2);
    bd = 32'h0BAD_0BAD;
    repeat (3) tick();
    chk("t3_recover_mask", error_o, 0);
    res = 1; en = 1;
    tick();
    res = 0;
    repeat (3) tick();
    bd = ad;
    repeat (5) tick();
    chk("t3_guard_mask", error_o, 0);
    chk("t3_cnt_hold", fault_cnt_o, 2);

    // T5 reset while recovering
    bd = ~ad;
    tick();
    bd = ad;
    tick();
    en = 0;
    tick();
    chk("t5_pre_cnt", fault_cnt_o, 3);
    rst_n = 0;
    #1;
    chk("t5_async_error", error_o, 0);
    chk("t5_async_cnt", fault_cnt_o, 0);
    chk("t5_async_perm", perm_fault_o, 0);
    tick();
    rst_n = 1; en = 1;
    repeat (2) tick();
    bd = ~ad;
    tick();
    bd = ad;
    tick();
    chk("t5_check_after", error_o, 1);
    ack_resume();

    // T4 threshold and saturation
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    repeat (THRESH - 1) fault_loop();
    chk("t4_perm_pre", perm_fault_o, 0);
    chk("t4_cnt_pre", fault_cnt_o, THRESH - 1);
    fault_loop();
    chk("t4_perm_set", perm_fault_o, 1);
    chk("t4_cnt_thr", fault_cnt_o, THRESH);
    repeat (300 - THRESH) fault_loop();
    chk("t4_cnt_sat", fault_cnt_o, 255);
    chk("t4_perm_sticky", perm_fault_o, 1);

`ifdef LOCKSTEP_CHECKER_DIVERGE_LOG_EN
    // T6 divergence capture
    ad = 32'h0000_00F0; bd = 32'h0000_00FF;
    tick();
    ad = 32'hDEAD_BEEF; bd = 32'hDEAD_BEEF;
    tick();
    chk("t6_error", error_o, 1);
    chk("t6_syn", syndrome_o, 32'h0000_000F);
    chk("t6_div_a", diverge_a_o, 32'h0000_00F0);
    chk("t6_div_b", diverge_b_o, 32'h0000_00FF);
    ack_resume();
    chk("t6_syn_hold", syndrome_o, 32'h0000_000F);
`endif

    run = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
